// File: rtl/traffic_display.sv
// traffic_display: display-side consumer of the traffic controller.
// The converter turns main/country remaining seconds into BCD one bit per clock
// (double dabble, main road first). The result drives a time-multiplexed 4-digit
// 7-segment display, with yellow-phase blinking and an illegal-lamp flag.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | watch count/count_c against the last converted values
// CONV_M | 8 shift-add iterations on the latched main-road value
// CONV_C | 8 shift-add iterations on the latched country-road value
module traffic_display #(
    parameter int unsigned SCAN_DIV  = 1000,
    parameter int unsigned BLINK_DIV = 50000
) (
    input  logic       clk,
    input  logic       set_n,
    input  logic [7:0] count,
    input  logic [7:0] count_c,
    input  logic       mr,
    input  logic       my,
    input  logic       mg,
    input  logic       cr,
    input  logic       cy,
    input  logic       cg,
    output logic [6:0] seg,
    output logic [3:0] dig_n,
    output logic       lamp_err
);

    localparam int SCAN_W  = $clog2(SCAN_DIV);
    localparam int BLINK_W = $clog2(BLINK_DIV);

    typedef enum logic [1:0] {IDLE, CONV_M, CONV_C} state_t;

    state_t               state_q, state_d;
    logic [7:0]           src_m_q, src_m_d, src_c_q, src_c_d;
    logic [19:0]          sh_q, sh_d;
    logic [2:0]           it_q, it_d;
    // BCD register layout: {dash, tens[3:0], ones[3:0]}
    logic [8:0]           bcd_m_q, bcd_m_d, bcd_c_q, bcd_c_d;
    logic [SCAN_W-1:0]    scan_cnt_q, scan_cnt_d;
    logic [1:0]           idx_q, idx_d;
    logic                 scan_on_q, scan_on_d;
    logic [BLINK_W-1:0]   blink_cnt_q, blink_cnt_d;
    logic                 phase_q, phase_d;
    logic [6:0]           seg_q, seg_d;
    logic [3:0]           dig_n_q, dig_n_d;
    logic                 lamp_err_q, lamp_err_d;

    logic [19:0]          adj, shifted;
    logic [8:0]           conv_res, bcd_sel;
    logic                 scan_wrap, blink_wrap, blink_now;
    logic [6:0]           code;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0: seg7 = 7'h3F;
            4'd1: seg7 = 7'h06;
            4'd2: seg7 = 7'h5B;
            4'd3: seg7 = 7'h4F;
            4'd4: seg7 = 7'h66;
            4'd5: seg7 = 7'h6D;
            4'd6: seg7 = 7'h7D;
            4'd7: seg7 = 7'h07;
            4'd8: seg7 = 7'h7F;
            4'd9: seg7 = 7'h6F;
            default: seg7 = 7'h00;
        endcase
    endfunction

    function automatic logic onehot3(input logic [2:0] v);
        onehot3 = (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
    endfunction

    // State and all datapath registers; reset abandons any conversion in flight
    always_ff @(posedge clk or negedge set_n) begin
        if (!set_n) begin
            state_q     <= IDLE;
            src_m_q     <= '0;
            src_c_q     <= '0;
            sh_q        <= '0;
            it_q        <= '0;
            bcd_m_q     <= '0;
            bcd_c_q     <= '0;
            scan_cnt_q  <= '0;
            idx_q       <= '0;
            scan_on_q   <= 1'b0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            seg_q       <= '0;
            dig_n_q     <= 4'b1111;
            lamp_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_m_q     <= src_m_d;
            src_c_q     <= src_c_d;
            sh_q        <= sh_d;
            it_q        <= it_d;
            bcd_m_q     <= bcd_m_d;
            bcd_c_q     <= bcd_c_d;
            scan_cnt_q  <= scan_cnt_d;
            idx_q       <= idx_d;
            scan_on_q   <= scan_on_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            seg_q       <= seg_d;
            dig_n_q     <= dig_n_d;
            lamp_err_q  <= lamp_err_d;
        end
    end

    // Next-state: main road wins when both values differ from their last conversion
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (count != src_m_q)        state_d = CONV_M;
                else if (count_c != src_c_q) state_d = CONV_C;
            end
            CONV_M, CONV_C: begin
                if (it_q == 3'd7) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Converter datapath: latch source, then adjust-and-shift; hundreds != 0 means dash
    always_comb begin
        src_m_d = src_m_q;
        src_c_d = src_c_q;
        sh_d    = sh_q;
        it_d    = it_q;
        bcd_m_d = bcd_m_q;
        bcd_c_d = bcd_c_q;
        adj     = sh_q;
        if (sh_q[11:8] >= 4'd5)  adj[11:8]  = sh_q[11:8] + 4'd3;
        if (sh_q[15:12] >= 4'd5) adj[15:12] = sh_q[15:12] + 4'd3;
        shifted  = adj << 1;
        conv_res = {(shifted[19:16] != 4'd0), shifted[15:8]};
        case (state_q)
            IDLE: begin
                it_d = 3'd0;
                if (count != src_m_q) begin
                    src_m_d = count;
                    sh_d    = {12'd0, count};
                end else if (count_c != src_c_q) begin
                    src_c_d = count_c;
                    sh_d    = {12'd0, count_c};
                end
            end
            CONV_M: begin
                sh_d = shifted;
                it_d = it_q + 3'd1;
                if (it_q == 3'd7) bcd_m_d = conv_res;
            end
            CONV_C: begin
                sh_d = shifted;
                it_d = it_q + 3'd1;
                if (it_q == 3'd7) bcd_c_d = conv_res;
            end
            default: ;
        endcase
    end

    // Scan, blink and segment select; seg is computed for the next index so it
    // changes on the same edge as dig_n
    always_comb begin
        scan_wrap   = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1));
        scan_cnt_d  = scan_wrap ? '0 : scan_cnt_q + SCAN_W'(1);
        idx_d       = scan_wrap ? idx_q + 2'd1 : idx_q;
        scan_on_d   = scan_on_q | scan_wrap;
        blink_wrap  = (blink_cnt_q == BLINK_W'(BLINK_DIV - 1));
        blink_cnt_d = blink_wrap ? '0 : blink_cnt_q + BLINK_W'(1);
        phase_d     = blink_wrap ? ~phase_q : phase_q;
        dig_n_d     = scan_on_d ? ~(4'b0001 << idx_d) : 4'b1111;

        bcd_sel   = idx_d[1] ? bcd_c_q : bcd_m_q;
        blink_now = phase_d & (idx_d[1] ? cy : my);
        if (bcd_sel[8])
            code = 7'h40;
        else if (bcd_sel[7:0] == 8'd0)
            code = 7'h00;
        else if (!idx_d[0])
            code = (bcd_sel[7:4] == 4'd0) ? 7'h00 : seg7(bcd_sel[7:4]);
        else
            code = seg7(bcd_sel[3:0]);
        seg_d = (!scan_on_d || blink_now) ? 7'h00 : code;

        lamp_err_d = !onehot3({mr, my, mg}) || !onehot3({cr, cy, cg}) || (mg && cg);
    end

    assign seg      = seg_q;
    assign dig_n    = dig_n_q;
    assign lamp_err = lamp_err_q;

endmodule
